// File: rtl/muldiv_pkg.sv
// Shared CPU definitions for the multiply/divide unit: op encodings and FSM states.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULDIV_MULT  = 2'b00,
    MULDIV_MULTU = 2'b01,
    MULDIV_DIV   = 2'b10,
    MULDIV_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } muldiv_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MULDIV_DIV) || (op == MULDIV_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MULDIV_MULT) || (op == MULDIV_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Handshake: start is taken only in IDLE (and not under flush); busy covers RUN+FIX; done pulses once after HI/LO update.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  muldiv_state_e state, next_state;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic             is_div_q;
  logic             neg_q;
  logic             rem_neg_q;
  logic             dz_q;

  logic             accept;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_take;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign busy   = (state != ST_IDLE);
  assign accept = (state == ST_IDLE) && start && !flush;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start && !flush) next_state = ST_RUN;
      ST_RUN: begin
        if (flush)                   next_state = ST_IDLE;
        else if (cnt == CNT_W'(1))   next_state = ST_FIX;
      end
      ST_FIX:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Signed ops run on magnitudes; min-int keeps its bit pattern, which is its correct unsigned magnitude.
  always_comb begin
    sign_a = op_is_signed(op) & src_a[WIDTH-1];
    sign_b = op_is_signed(op) & src_b[WIDTH-1];
    mag_a  = sign_a ? -src_a : src_a;
    mag_b  = sign_b ? -src_b : src_b;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_take  = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[WIDTH-1:0] - opnd;
  end

  // A zero divisor leaves |a| as remainder, so the remainder sign fix restores src_a exactly.
  always_comb begin
    prod_raw = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    quo_fix  = dz_q ? {WIDTH{1'b1}} : (neg_q ? -acc_lo : acc_lo);
    rem_fix  = rem_neg_q ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      is_div_q    <= 1'b0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      dz_q        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (accept) begin
            cnt       <= CNT_W'(WIDTH);
            acc_hi    <= '0;
            acc_lo    <= op_is_div(op) ? mag_a : mag_b;
            opnd      <= op_is_div(op) ? mag_b : mag_a;
            is_div_q  <= op_is_div(op);
            neg_q     <= sign_a ^ sign_b;
            rem_neg_q <= sign_a;
            dz_q      <= op_is_div(op) && (src_b == '0);
          end
        end
        ST_RUN: begin
          if (!flush) begin
            cnt <= cnt - CNT_W'(1);
            if (is_div_q) begin
              acc_hi <= div_take ? div_diff : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_take};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
          end
        end
        ST_FIX: begin
          if (!flush) begin
            hi          <= is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo          <= is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
            done        <= 1'b1;
            div_by_zero <= dz_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected {div_by_zero, hi, lo} popped on done.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int EW = 2 * W + 1;

  logic         clock = 1'b0;
  logic         reset, start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b, wdata, hi, lo;
  logic         busy, done, div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [EW-1:0] exp_q[$];
  int            start_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  // clock / cycle count
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sp;
    logic [2*W-1:0]        up;
    logic signed [W-1:0]   sq, sr;
    case (o)
      2'b00: begin
        sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        return {1'b0, sp};
      end
      2'b01: begin
        up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return {1'b0, up};
      end
      2'b10: begin
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, {W{1'b0}}, a};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {1'b0, sr, sq};
      end
      default: begin
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = 32'h8000_0000;
      2:       v = W'($urandom_range(1, 20));
      3:       v = -W'($urandom_range(1, 20));
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // scoreboard: every done must match the oldest expected result and arrive WIDTH+1 edges after issue
  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", EW'(done), EW'(0));
      end else begin
        logic [EW-1:0] e;
        int k;
        e = exp_q.pop_front();
        k = start_q.pop_front();
        check("hi", EW'(hi), EW'(e[2*W-1:W]));
        check("lo", EW'(lo), EW'(e[W-1:0]));
        check("div_by_zero", EW'(div_by_zero), EW'(e[2*W]));
        check("latency", EW'(cyc - k), EW'(W + 1));
        check("busy_at_done", EW'(busy), EW'(0));
      end
    end
  end

  // driver: caller is at a negedge; start is held for exactly one cycle
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_done, input logic [EW-1:0] e, output int k);
    start = 1'b1; op = o; src_a = a; src_b = b;
    k = cyc + 1;
    if (expect_done) begin
      exp_q.push_back(e);
      start_q.push_back(k);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 60) begin
      @(negedge clock);
      if (done) break;
      n++;
    end
    if (n == 60) check("done_timeout", EW'(done), EW'(1));
  endtask

  task automatic write_hilo(input logic whi, input logic wlo, input logic [W-1:0] d);
    hi_we = whi; lo_we = wlo; wdata = d;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    int k;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;

    reset = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", EW'(busy), EW'(0));
    check("reset_done", EW'(done), EW'(0));
    check("reset_dz", EW'(div_by_zero), EW'(0));
    check("reset_hi", EW'(hi), EW'(0));
    check("reset_lo", EW'(lo), EW'(0));
    reset = 1'b0;
    @(negedge clock);

    // MULT -3*5 with busy window k+1 .. k+W+1
    issue(2'b00, -32'sd3, 32'd5, 1'b1, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1}, k);
    check("mult_busy", EW'(busy), EW'(1));
    for (int i = 2; i <= W + 1; i++) begin
      @(negedge clock);
      check("mult_busy", EW'(busy), EW'(1));
    end
    wait_done();

    issue(2'b11, 32'd100, 32'd7, 1'b1, {1'b0, 32'h0000_0002, 32'h0000_000E}, k);
    wait_done();
    issue(2'b10, -32'sd7, 32'd2, 1'b1, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, k);
    wait_done();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {1'b0, 32'h0000_0000, 32'h8000_0000}, k);
    wait_done();
    issue(2'b10, 32'd5, 32'd0, 1'b1, {1'b1, 32'h0000_0005, 32'hFFFF_FFFF}, k);
    wait_done();
    issue(2'b10, -32'sd5, 32'd0, 1'b1, {1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF}, k);
    wait_done();

    // flush mid-MULTU: ignored start at k+5, MTHI while busy at k+7, flush at k+10
    write_hilo(1'b1, 1'b0, 32'h0000_1234);
    check("mthi", EW'(hi), EW'(32'h0000_1234));
    issue(2'b01, 32'd1000, 32'd3000, 1'b0, '0, k);
    while (cyc + 1 < k + 10) begin
      @(negedge clock);
      start = (cyc + 1 == k + 5);
      op = 2'b10; src_a = 32'd9; src_b = 32'd3;
      hi_we = (cyc + 1 == k + 7); wdata = 32'hDEAD_BEEF;
      flush = (cyc + 1 == k + 10);
    end
    start = 1'b0; hi_we = 1'b0;
    @(negedge clock);
    flush = 1'b0;
    check("flush_busy", EW'(busy), EW'(0));
    check("flush_hi", EW'(hi), EW'(32'h0000_1234));
    repeat (40) @(negedge clock);
    check("flush_hi_later", EW'(hi), EW'(32'h0000_1234));

    // flush in IDLE suppresses a same-cycle start
    flush = 1'b1;
    issue(2'b01, 32'd2, 32'd3, 1'b0, '0, k);
    flush = 1'b0;
    check("flush_idle_busy", EW'(busy), EW'(0));

    // MTHI/MTLO in the start cycle lands, then the result overwrites it
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'd55;
    issue(2'b01, 32'd6, 32'd7, 1'b1, {1'b0, 32'd0, 32'd42}, k);
    hi_we = 1'b0; lo_we = 1'b0;
    check("start_mthi", EW'(hi), EW'(32'd55));
    check("start_mtlo", EW'(lo), EW'(32'd55));
    wait_done();

    // random back-to-back ops, each issued in the done cycle of the previous one
    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = rand_operand();
      rb = rand_operand();
      issue(ro, ra, rb, 1'b1, model(ro, ra, rb), k);
      wait_done();
    end

    // reset at k+20 of a DIVU
    write_hilo(1'b1, 1'b1, 32'h0000_ABCD);
    issue(2'b11, 32'd12345, 32'd17, 1'b0, '0, k);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_busy", EW'(busy), EW'(0));
    check("rst_mid_hi", EW'(hi), EW'(0));
    check("rst_mid_lo", EW'(lo), EW'(0));
    check("rst_mid_done", EW'(done), EW'(0));
    reset = 1'b0;
    @(negedge clock);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {1'b0, 32'd0, 32'd1}, k);
    wait_done();
    repeat (5) @(negedge clock);
    check("queue_empty", EW'(exp_q.size()), EW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Replaces single-cycle divide in the execute stage.
- Sits beside the execute stage. Accepts MULT/MULTU/DIV/DIVU issue, runs a radix-2 iterative datapath, and retires the result into HI/LO.
- Exposes busy/done so the hazard unit stalls MFHI/MFLO and back-to-back mult/div ops.

Parameters:
- WIDTH, 32, operand width and HI/LO width; even, >= 4.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  issue request, sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  WIDTH  multiplicand / dividend (rs)
- src_b  in  WIDTH  multiplier / divisor (rt)
- flush  in  1  abort the in-flight operation (exception/trap flush)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight (state != IDLE)
- done  out  1  one-cycle pulse when HI/LO have been updated by a mult/div
- div_by_zero  out  1  pulses with done when the divisor was 0
- hi  out  WIDTH  HI register (remainder / product upper half)
- lo  out  WIDTH  LO register (quotient / product lower half)

Behaviour:
- Reset (any cycle, including mid-operation):
  - state=IDLE, hi=0, lo=0.
  - busy=0, done=0, div_by_zero=0.
  - Counter and datapath registers are cleared.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1 at edge k:
  - Latch op and operand signs.
  - Latch absolute values for signed ops, raw values for unsigned ops.
  - counter=WIDTH; go to RUN.
- RUN: one iteration per cycle; counter decrements; at counter==1 go to FIX.
  - MUL: shift-add, 2*WIDTH-bit accumulator.
  - DIV: restoring divide producing one quotient bit per cycle.
- FIX (one cycle): apply sign correction, then at the edge ending FIX write hi/lo, assert done, return to IDLE.
- Latency:
  - busy=1 in cycles k+1 .. k+WIDTH+1.
  - done=1 in cycle k+WIDTH+2 only, with busy=0 in that cycle.
  - hi/lo show the new values from cycle k+WIDTH+2.
- Sign rules:
  - Product sign = sign(a) XOR sign(b), negated over the full 2*WIDTH bits.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - Unsigned ops: no correction.
- DIV with min-int / -1: LO=min-int (wraps), HI=0.
- Divisor 0 (DIV or DIVU):
  - Same latency as a normal divide.
  - HI=src_a as issued, LO=all ones.
  - div_by_zero=1 together with done.
- start while busy: ignored; no queuing.
- flush:
  - While busy: next edge returns to IDLE; hi/lo unchanged; no done.
  - In IDLE: suppresses a same-cycle start.
- flush and reset together: reset wins.
- hi_we/lo_we:
  - Honoured only in IDLE; ignored while busy.
  - Same cycle as start in IDLE: the write lands, and the later result overwrites it.
- The edge completing FIX has priority over nothing else; a start in the done cycle is accepted (state is IDLE).

Decomposition:
- Shared package (existing CPU definitions package): op encodings MULDIV_MULT/MULTU/DIV/DIVU and the FSM state encoding.
- Counter width is a localparam, $clog2(WIDTH+1).
- No sub-module: the datapath and FSM are a single block of about 200 lines.

Test Plan (WIDTH=32):
- MULT -3 * 5, start at cycle k -> done at k+34; HI=FFFFFFFF, LO=FFFFFFF1; busy high k+1..k+33.
- DIVU 100 / 7 -> LO=0000000E, HI=00000002; div_by_zero=0.
- DIV -7 / 2 -> LO=FFFFFFFD, HI=FFFFFFFF. Then DIV 80000000 / FFFFFFFF -> LO=80000000, HI=00000000.
- DIV 5 / 0 -> HI=00000005, LO=FFFFFFFF, div_by_zero=1 coincident with done.
- MTHI 1234 loaded, then MULTU issued; flush at k+10 -> busy=0 at k+11, no done, HI=00001234 retained. A start at k+5 is ignored.
- reset asserted at k+20 of a DIVU -> next cycle busy=0, hi=lo=0, no done. hi_we during busy has no effect.
